// File: rtl/blk_copy_seq.sv
`default_nettype none
// ============================================================================
// Module   : blk_copy_seq
// Purpose  : Memory block-copy sequencer. While running it borrows the CPU
//            register file B-port and inc/dec controls, using register pairs
//            {r(n+1),r(n)} as 16-bit source / destination pointers that are
//            post-incremented after every memory access.
// Options  : BLK_COPY_DIR_EN - adds i_dir; i_dir=1 at start gives a
//            descending copy (rf_dec instead of rf_inc).
// Ports    : clk, rst_n            clock, async active-low reset
//            i_start/i_src_pair/i_dst_pair/i_count/i_abort  control
//            o_busy/o_done/o_err/o_aborted                  status
//            o_rf_own/o_rf_outb_sel/o_rf_inc/o_rf_dec       register-file side
//            i_rf_outb/i_rf_outc                            pointer bytes
//            o_mem_addr/o_mem_rd/o_mem_wr/o_mem_wdata/i_mem_rdata  memory
// Revision : 1.0 - initial release
// ============================================================================
module blk_copy_seq #(
  parameter int CNT_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [3:0]       i_src_pair,
  input  logic [3:0]       i_dst_pair,
  input  logic [CNT_W-1:0] i_count,
`ifdef BLK_COPY_DIR_EN
  input  logic             i_dir,
`endif
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic             o_aborted,
  output logic             o_rf_own,
  output logic [3:0]       o_rf_outb_sel,
  output logic             o_rf_inc,
  output logic             o_rf_dec,
  input  logic [7:0]       i_rf_outb,
  input  logic [7:0]       i_rf_outc,
  output logic [15:0]      o_mem_addr,
  output logic             o_mem_rd,
  output logic             o_mem_wr,
  output logic [7:0]       o_mem_wdata,
  input  logic [7:0]       i_mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_NEXT = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  // Index of the last WAIT cycle: read data is valid there.
  localparam logic [1:0] c_WAIT_LAST = 2'(RD_LAT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_src;
  logic [3:0]       r_dst;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_data;
  logic [1:0]       r_wcnt;
  logic             r_abt_seen;
  logic             r_abt_exit;
  logic             r_done;
  logic             r_err;
  logic             r_aborted;
  logic             w_odd;
  logic             w_access;
  logic             w_desc;
  logic [CNT_W-1:0] w_cnt_dec;

  assign w_odd     = i_src_pair[0] | i_dst_pair[0];
  assign w_cnt_dec = r_cnt - CNT_W'(1);

`ifdef BLK_COPY_DIR_EN
  logic r_dir;
  assign w_desc = r_dir;
`else
  assign w_desc = 1'b0;
`endif

  // Pointer bytes come straight from the selected register pair.
  assign o_mem_addr = {i_rf_outc, i_rf_outb};
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_aborted  = r_aborted;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_state_nxt   = r_state;
    o_busy        = 1'b1;
    o_rf_outb_sel = 4'd0;
    o_mem_rd      = 1'b0;
    o_mem_wr      = 1'b0;
    o_mem_wdata   = 8'd0;
    w_access      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start && !w_odd) begin
          w_state_nxt = (i_count == '0) ? S_FIN : S_RD;
        end
      end
      S_RD: begin
        o_rf_outb_sel = r_src;
        o_mem_rd      = 1'b1;
        w_access      = 1'b1;
        w_state_nxt   = S_WAIT;
      end
      S_WAIT: begin
        if (r_wcnt == c_WAIT_LAST) begin
          w_state_nxt = S_WR;
        end
      end
      S_WR: begin
        o_rf_outb_sel = r_dst;
        o_mem_wr      = 1'b1;
        o_mem_wdata   = r_data;
        w_access      = 1'b1;
        w_state_nxt   = S_NEXT;
      end
      S_NEXT: begin
        // An abort arriving in this very cycle still counts for this byte.
        if ((w_cnt_dec == '0) || r_abt_seen || i_abort) begin
          w_state_nxt = S_FIN;
        end else begin
          w_state_nxt = S_RD;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        o_busy      = 1'b0;
      end
    endcase
  end

  assign o_rf_own = o_busy;
  // Exactly one of inc/dec can be active during an access.
  assign o_rf_inc = w_access & ~w_desc;
  assign o_rf_dec = w_access &  w_desc;

  // Datapath and sticky status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src      <= 4'd0;
      r_dst      <= 4'd0;
      r_cnt      <= '0;
      r_data     <= 8'd0;
      r_wcnt     <= 2'd0;
      r_abt_seen <= 1'b0;
      r_abt_exit <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_aborted  <= 1'b0;
`ifdef BLK_COPY_DIR_EN
      r_dir      <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE && i_abort) begin
        r_abt_seen <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (w_odd) begin
              // Rejected request: flag it and still hand back a done pulse.
              r_err  <= 1'b1;
              r_done <= 1'b1;
            end else begin
              r_src      <= i_src_pair;
              r_dst      <= i_dst_pair;
              r_cnt      <= i_count;
              r_err      <= 1'b0;
              r_aborted  <= 1'b0;
              r_abt_seen <= 1'b0;
              r_abt_exit <= 1'b0;
`ifdef BLK_COPY_DIR_EN
              r_dir      <= i_dir;
`endif
            end
          end
        end
        S_RD: begin
          r_wcnt <= 2'd0;
        end
        S_WAIT: begin
          r_wcnt <= r_wcnt + 2'd1;
          if (r_wcnt == c_WAIT_LAST) begin
            r_data <= i_mem_rdata;
          end
        end
        S_NEXT: begin
          r_cnt <= w_cnt_dec;
          // A run that finishes its count anyway is not reported as aborted.
          r_abt_exit <= (w_cnt_dec != '0) && (r_abt_seen || i_abort);
        end
        S_FIN: begin
          r_done <= 1'b1;
          if (r_abt_exit) begin
            r_aborted <= 1'b1;
          end
        end
        default: begin
          r_wcnt <= 2'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_blk_copy_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_blk_copy_seq
// Purpose  : Self-checking bench for blk_copy_seq with a register-file model
//            and a 64 KiB byte memory model (read latency 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_blk_copy_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  src_pair = 4'd0;
  logic [3:0]  dst_pair = 4'd0;
  logic [7:0]  count = 8'd0;
  logic        abort = 1'b0;
`ifdef BLK_COPY_DIR_EN
  logic        dir = 1'b0;
`endif
  logic        busy, done, err, aborted, rf_own, rf_inc, rf_dec;
  logic [3:0]  rf_outb_sel;
  logic [7:0]  rf_outb, rf_outc, mem_wdata;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_rdata = 8'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  blk_copy_seq #(.CNT_W(8), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_src_pair(src_pair),
    .i_dst_pair(dst_pair), .i_count(count),
`ifdef BLK_COPY_DIR_EN
    .i_dir(dir),
`endif
    .i_abort(abort), .o_busy(busy), .o_done(done), .o_err(err),
    .o_aborted(aborted), .o_rf_own(rf_own), .o_rf_outb_sel(rf_outb_sel),
    .o_rf_inc(rf_inc), .o_rf_dec(rf_dec), .i_rf_outb(rf_outb),
    .i_rf_outc(rf_outc), .o_mem_addr(mem_addr), .o_mem_rd(mem_rd),
    .o_mem_wr(mem_wr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  // ---------------- register file model ----------------
  logic [7:0]  rf [16];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_pair = 4'd0;
  logic [15:0] pl_val = 16'd0;

  assign rf_outb = rf[rf_outb_sel];
  assign rf_outc = rf[rf_outb_sel + 4'd1];

  always @(posedge clk) begin
    if (pl_en) begin
      rf[pl_pair]        <= pl_val[7:0];
      rf[pl_pair + 4'd1] <= pl_val[15:8];
    end else if (rf_inc) begin
      {rf[rf_outb_sel + 4'd1], rf[rf_outb_sel]} <= {rf_outc, rf_outb} + 16'd1;
    end else if (rf_dec) begin
      {rf[rf_outb_sel + 4'd1], rf[rf_outb_sel]} <= {rf_outc, rf_outb} - 16'd1;
    end
  end

  // ---------------- memory model ----------------
  bit [7:0]    mem [65536];
  bit          wrt [65536];
  logic [15:0] rd_q[$];
  logic [15:0] wr_a[$];
  logic [7:0]  wr_d[$];
  int          both_hi = 0;
  int          own_bad = 0;

  function automatic logic [7:0] pattern(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] mem_val(input logic [15:0] a);
    return wrt[a] ? mem[a] : pattern(a);
  endfunction

  always @(posedge clk) begin
    mem_rdata <= mem_val(mem_addr);
    if (mem_rd) rd_q.push_back(mem_addr);
    if (mem_wr) begin
      wr_a.push_back(mem_addr);
      wr_d.push_back(mem_wdata);
      mem[mem_addr] <= mem_wdata;
      wrt[mem_addr] <= 1'b1;
    end
    if (rf_inc && rf_dec) both_hi++;
  end

  always @(negedge clk) if (rf_own !== busy) own_bad++;

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_pair(input logic [3:0] p, input logic [15:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_pair = p; pl_val = v;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  function automatic logic [15:0] get_pair(input logic [3:0] p);
    return {rf[p + 4'd1], rf[p]};
  endfunction

  function automatic logic [31:0] outs_vec();
    return {8'd0, busy, done, err, aborted, rf_own, rf_inc, rf_dec, mem_rd,
            mem_wr, rf_outb_sel, mem_wdata};
  endfunction

  typedef struct {
    logic [3:0]  sp, dp;
    logic [15:0] sptr, dptr;
    logic [7:0]  cnt;
    logic        dir;
    int          abort_at;
    logic        pre_abort;
    int          lat, busy_cyc, nb;
    logic [15:0] send, dend;
    logic        err, abt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [3:0] sp, logic [3:0] dp, logic [15:0] sptr,
      logic [15:0] dptr, logic [7:0] cnt, logic dr, int abort_at, logic pre_abort,
      int lat, int busy_cyc, int nb, logic [15:0] send, logic [15:0] dend,
      logic e, logic a);
    vec_t v;
    v.sp = sp; v.dp = dp; v.sptr = sptr; v.dptr = dptr; v.cnt = cnt; v.dir = dr;
    v.abort_at = abort_at; v.pre_abort = pre_abort; v.lat = lat;
    v.busy_cyc = busy_cyc; v.nb = nb; v.send = send; v.dend = dend;
    v.err = e; v.abt = a;
    return v;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int n, lat, busy_hi, rb, wb, bad;
    logic [15:0] ra, wa, stp, inc;
    string pfx;
    pfx = $sformatf("v%0d_", idx);
    set_pair(v.sp, v.sptr);
    if (v.dp != v.sp) set_pair(v.dp, v.dptr);
    rb = rd_q.size();
    wb = wr_a.size();
    if (v.pre_abort) begin
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
    end
    @(negedge clk);
    start = 1'b1; src_pair = v.sp; dst_pair = v.dp; count = v.cnt;
`ifdef BLK_COPY_DIR_EN
    dir = v.dir;
`endif
    @(negedge clk);
    start = 1'b0;
    n = 1; lat = 0; busy_hi = 0;
    while (n < 300) begin
      if (done) begin
        lat = n;
        break;
      end
      if (busy) busy_hi++;
      abort = (n == v.abort_at);
      @(negedge clk);
      n++;
    end
    abort = 1'b0;
    chk({pfx, "done_lat"}, lat, v.lat);
    chk({pfx, "busy_cycles"}, busy_hi, v.busy_cyc);
    chk({pfx, "err"}, err, v.err);
    chk({pfx, "aborted"}, aborted, v.abt);
    @(negedge clk);
    chk({pfx, "done_pulse"}, done, 1'b0);
    chk({pfx, "reads"}, rd_q.size() - rb, v.nb);
    chk({pfx, "writes"}, wr_a.size() - wb, v.nb);
    chk({pfx, "src_ptr"}, get_pair(v.sp), v.send);
    chk({pfx, "dst_ptr"}, get_pair(v.dp), v.dend);
    stp = v.dir ? 16'hFFFF : 16'h0001;
    ra = v.sptr;
    wa = (v.sp == v.dp) ? v.sptr + stp : v.dptr;
    inc = (v.sp == v.dp) ? stp + stp : stp;
    bad = 0;
    for (int i = 0; i < v.nb; i++) begin
      if (rb + i >= rd_q.size() || wb + i >= wr_a.size()) bad++;
      else if (rd_q[rb + i] !== ra || wr_a[wb + i] !== wa ||
               wr_d[wb + i] !== pattern(ra) || mem_val(wa) !== pattern(ra)) bad++;
      ra = ra + inc;
      wa = wa + inc;
    end
    chk({pfx, "addr_data_seq"}, bad, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int wb;
    for (int i = 0; i < 16; i++) rf[i] = 8'd0;
    // sp dp sptr dptr cnt dir abort_at pre_abort lat busy nb send dend err abt
    vecs.push_back(mk(0, 2, 16'h1000, 16'h2000, 4, 0, 0, 0, 18, 17, 4, 16'h1004, 16'h2004, 0, 0));
    vecs.push_back(mk(4, 6, 16'h3000, 16'h4000, 0, 0, 0, 0, 2, 1, 0, 16'h3000, 16'h4000, 0, 0));
    vecs.push_back(mk(3, 8, 16'h1234, 16'h5000, 5, 0, 0, 0, 1, 0, 0, 16'h1234, 16'h5000, 1, 0));
    vecs.push_back(mk(2, 5, 16'h2222, 16'h3333, 3, 0, 0, 0, 1, 0, 0, 16'h2222, 16'h3333, 1, 0));
    vecs.push_back(mk(8, 10, 16'h5000, 16'h6000, 1, 0, 0, 0, 6, 5, 1, 16'h5001, 16'h6001, 0, 0));
    vecs.push_back(mk(0, 2, 16'hFFFF, 16'h7000, 2, 0, 0, 0, 10, 9, 2, 16'h0001, 16'h7002, 0, 0));
    vecs.push_back(mk(12, 14, 16'h8000, 16'h9000, 10, 0, 10, 0, 14, 13, 3, 16'h8003, 16'h9003, 0, 1));
    vecs.push_back(mk(0, 2, 16'h1100, 16'h1200, 1, 0, 0, 1, 6, 5, 1, 16'h1101, 16'h1201, 0, 0));
    vecs.push_back(mk(4, 4, 16'h3000, 16'h3000, 2, 0, 0, 0, 10, 9, 2, 16'h3004, 16'h3004, 0, 0));
`ifdef BLK_COPY_DIR_EN
    vecs.push_back(mk(0, 2, 16'h1003, 16'h2103, 4, 1, 0, 0, 18, 17, 4, 16'h0FFF, 16'h20FF, 0, 0));
`endif

    repeat (3) @(negedge clk);
    chk("reset_outputs", outs_vec(), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", outs_vec(), 32'd0);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset during the first byte's write cycle.
    set_pair(6, 16'hA000);
    set_pair(8, 16'hB000);
    wb = wr_a.size();
    @(negedge clk);
    start = 1'b1; src_pair = 4'd6; dst_pair = 4'd8; count = 8'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_wr", {busy, mem_wr, rf_inc}, 3'b111);
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", outs_vec(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_src_ptr", get_pair(6), 16'hA001);
    chk("rst_dst_ptr", get_pair(8), 16'hB000);
    chk("rst_no_write", wr_a.size() - wb, 0);
    run_vec(99, mk(6, 8, 16'hA000, 16'hB000, 2, 0, 0, 0, 10, 9, 2, 16'hA002, 16'hB002, 0, 0));

    chk("inc_dec_exclusive", both_hi, 0);
    chk("rf_own_eq_busy", own_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/blk_copy_seq.md
Name: blk_copy_seq

Overview:
- Memory block-copy sequencer that borrows the CPU register file while it runs.
- Register pairs {r(n+1),r(n)} serve as 16-bit source and destination pointers. The block drives the register file's outBselect/inc/dec controls to read both pointers and post-increment them after each access.
- Sits beside the CPU core. A CPU-side mux hands the register-file B-port and inc/dec controls to this block while rf_own=1.
- Frees the core from byte-by-byte copy loops.

Parameters:
- CNT_W, 8, width of the transfer count; max transfer is 2^CNT_W-1 bytes.
- RD_LAT, 1, memory read latency in cycles (legal 1..3).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request pulse; sampled only in IDLE
- src_pair  in  4  source pointer pair select; must be even
- dst_pair  in  4  destination pointer pair select; must be even
- count  in  CNT_W  number of bytes to copy
- abort  in  1  stop after the byte currently in flight
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when returning to IDLE after an accepted start
- err  out  1  sticky; set by an odd pair select; cleared by the next accepted legal start
- aborted  out  1  sticky; set when a run ends by abort; cleared by the next accepted start
- rf_own  out  1  block owns the register-file B-port and inc/dec; equals busy
- rf_outb_sel  out  4  drives register-file outBselect
- rf_inc  out  1  drives register-file inc
- rf_dec  out  1  drives register-file dec
- rf_outb  in  8  register-file outB (pointer low byte)
- rf_outc  in  8  register-file outC (pointer high byte)
- mem_addr  out  16  {rf_outc, rf_outb}; combinational from the selected pair
- mem_rd  out  1  read strobe
- mem_wr  out  1  write strobe
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data, valid RD_LAT cycles after the mem_rd cycle

Behaviour:
- Reset (async, rst_n=0): state IDLE. Outputs busy, done, err, aborted, rf_own, rf_inc, rf_dec, mem_rd, mem_wr = 0. rf_outb_sel, mem_wdata = 0. Internal counter and data latch = 0.
- States: IDLE, RD, WAIT, WR, NEXT, FIN.
- IDLE:
  - start with src_pair[0] or dst_pair[0] set: set err, pulse done next cycle, stay IDLE, no register-file or memory activity.
  - start with legal pairs and count=0: go to FIN.
  - start with legal pairs and count>0: latch pairs and count, clear err and aborted, go to RD.
- RD (1 cycle): rf_outb_sel=src; mem_rd=1; rf_inc=1. Address is sampled by memory at the same edge the pointer increments (post-increment).
- WAIT (RD_LAT cycles): mem_rdata is captured into the data latch on the last WAIT cycle.
- WR (1 cycle): rf_outb_sel=dst; mem_wr=1; mem_wdata=latch; rf_inc=1.
- NEXT (1 cycle): counter decrements. Go to FIN if counter hits 0 or abort was seen during this byte; otherwise go to RD.
- FIN (1 cycle): done=1; go to IDLE. busy and rf_own drop on entry to IDLE.
- Throughput: 3+RD_LAT cycles per byte. Total = 2 + N*(3+RD_LAT) cycles from start to IDLE.
- Pointers wrap 0xFFFF→0x0000 via register-file arithmetic; no special handling.
- src_pair==dst_pair is legal: read and write alternate on the same advancing pointer.
- abort: latched in any busy state. The current byte always completes (no torn read without write). aborted is set on FIN. abort in IDLE is ignored.
- start while busy: ignored.
- rf_inc and rf_dec are never both high.
- rst_n asserted mid-run: immediate IDLE. Pointer registers keep whatever increments were already applied.

Optional Feature:
- Macro BLK_COPY_DIR_EN.
- When defined:
  - Adds input port dir (1 bit), latched at start.
  - dir=1 uses rf_dec instead of rf_inc in RD and WR, giving a descending copy for overlapping moves.
- When undefined:
  - No dir port; always ascending; rf_dec tied to 0.

Test Plan:
- Ascending copy, RD_LAT=1:
  - Stimulus: r1:r0=0x1000, r3:r2=0x2000, mem[0x1000..0x1003]=A0..A3; start src=0, dst=2, count=4.
  - Required: mem[0x2000..0x2003]=A0..A3; r1:r0=0x1004, r3:r2=0x2004; done exactly 18 cycles after start; busy high throughout.
- count=0:
  - Stimulus: start with count=0.
  - Required: no mem_rd/mem_wr, pointers unchanged, done pulse 2 cycles after start.
- Odd pair:
  - Stimulus: start with src_pair=3.
  - Required: err=1, done pulse, busy never rises, no memory strobes. A following legal start clears err.
- Pointer wrap:
  - Stimulus: src pointer 0xFFFF, count=2.
  - Required: reads at 0xFFFF then 0x0000; final pointer 0x0001.
- Abort mid-run:
  - Stimulus: count=10; abort pulsed during the 3rd byte's WAIT.
  - Required: exactly 3 writes, aborted=1, counter stops, pointers advanced by 3.
- Reset mid-run:
  - Stimulus: rst_n low during WR.
  - Required: all outputs 0 asynchronously; next start runs normally.
  - Required, with BLK_COPY_DIR_EN and dir=1, src 0x1003, count=4: descending addresses 0x1003..0x1000.
